// File: rtl/swim_pkg.sv
// Shared state encoding, timing defaults and helpers for the SWIM entry sequencer.
package swim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NRST_HOLD,
    ST_ENTRY_LOW,
    ST_ENTRY_HIGH,
    ST_PATTERN,
    ST_SYNC_WAIT,
    ST_END
  } swim_state_t;

  // 48 MHz silicon timings
  localparam int unsigned HW_RST_CYCLES          = 480000;
  localparam int unsigned HW_START_LOW_CYCLES    = 768;
  localparam int unsigned HW_START_HIGH_CYCLES   = 48000;
  localparam int unsigned HW_BIT_CYCLES          = 12000;
  localparam int unsigned HW_SYNC_MIN_CYCLES     = 96;
  localparam int unsigned HW_SYNC_TIMEOUT_CYCLES = 96000;
  localparam int unsigned HW_END_CYCLES          = 480000;

  // Shortened timings for simulation
  localparam int unsigned SIM_RST_CYCLES          = 10;
  localparam int unsigned SIM_START_LOW_CYCLES    = 2;
  localparam int unsigned SIM_START_HIGH_CYCLES   = 10;
  localparam int unsigned SIM_BIT_CYCLES          = 4;
  localparam int unsigned SIM_PAT_WIDTH           = 8;
  localparam logic [7:0]  SIM_PATTERN             = 8'hA5;
  localparam int unsigned SIM_SYNC_MIN_CYCLES     = 3;
  localparam int unsigned SIM_SYNC_TIMEOUT_CYCLES = 40;
  localparam int unsigned SIM_END_CYCLES          = 20;

  localparam int unsigned DEF_PAT_WIDTH = 28;
  localparam logic [27:0] DEF_PATTERN   = 28'h0CCCCAA;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/swim_sync_det.sv
// Per-channel sync-pulse detector: 2-FF synchroniser, saturating low-width counter, sticky ack.
module swim_sync_det #(
  parameter int unsigned SYNC_MIN_CYCLES = 96
) (
  input  logic clk,
  input  logic rst,
  input  logic swim_in,
  input  logic en,
  input  logic clear,
  output logic ack
);

  localparam int unsigned LW = (SYNC_MIN_CYCLES > 0) ? $clog2(SYNC_MIN_CYCLES + 1) : 1;

  logic          s1;
  logic          s2;
  logic          armed;
  logic [LW-1:0] low_cnt;

  // A low only counts once a high has been seen while enabled, so a pulse
  // already running when the window opens can never produce an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      armed   <= 1'b0;
      low_cnt <= '0;
      ack     <= 1'b0;
    end else begin
      s1 <= swim_in;
      s2 <= s1;
      if (clear) begin
        armed   <= 1'b0;
        low_cnt <= '0;
        ack     <= 1'b0;
      end else if (!en) begin
        armed   <= 1'b0;
        low_cnt <= '0;
      end else if (s2) begin
        armed   <= 1'b1;
        low_cnt <= '0;
        if (low_cnt != '0 && low_cnt >= LW'(SYNC_MIN_CYCLES))
          ack <= 1'b1;
      end else if (armed && low_cnt != '1) begin
        low_cnt <= low_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/swim_entry_seq.sv
// Multi-channel SWIM entry sequencer: NRST hold, entry pulse, activation pattern, sync detection.
module swim_entry_seq
  import swim_pkg::*;
#(
  parameter int unsigned           NUM_CH              = 3,
  parameter int unsigned           RST_CYCLES          = HW_RST_CYCLES,
  parameter int unsigned           START_LOW_CYCLES    = HW_START_LOW_CYCLES,
  parameter int unsigned           START_HIGH_CYCLES   = HW_START_HIGH_CYCLES,
  parameter int unsigned           BIT_CYCLES          = HW_BIT_CYCLES,
  parameter int unsigned           PAT_WIDTH           = DEF_PAT_WIDTH,
  parameter logic [PAT_WIDTH-1:0]  PATTERN             = PAT_WIDTH'(DEF_PATTERN),
  parameter int unsigned           SYNC_MIN_CYCLES     = HW_SYNC_MIN_CYCLES,
  parameter int unsigned           SYNC_TIMEOUT_CYCLES = HW_SYNC_TIMEOUT_CYCLES,
  parameter int unsigned           END_CYCLES          = HW_END_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] swim_in,
  output logic [NUM_CH-1:0] swim_oe,
  output logic              nrst,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] ack,
  output logic              err
);

  localparam int unsigned MAX_T = max2(max2(max2(RST_CYCLES, START_LOW_CYCLES),
                                            max2(START_HIGH_CYCLES, BIT_CYCLES)),
                                       max2(SYNC_TIMEOUT_CYCLES, END_CYCLES));
  localparam int unsigned CW = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int unsigned BW = (PAT_WIDTH > 1) ? $clog2(PAT_WIDTH) : 1;

  swim_state_t       state;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_idx;
  logic [BW-1:0]     next_idx;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] ack_int;
  logic              cnt_zero;
  logic              start_ok;
  logic              all_acked;
  logic              sync_en;

  always_comb begin
    cnt_zero  = (cnt == '0);
    start_ok  = (state == ST_IDLE) && start && (|ch_mask) && !abort;
    all_acked = ((ack_int & mask) == mask);
    sync_en   = (state == ST_SYNC_WAIT);
    next_idx  = bit_idx - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      mask    <= '0;
      swim_oe <= '0;
      nrst    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE && abort) begin
        state   <= ST_IDLE;
        swim_oe <= '0;
        nrst    <= 1'b1;
        busy    <= 1'b0;
        done    <= 1'b1;
        err     <= 1'b1;
      end else begin
        // Each timed state loads (duration-1) on entry and leaves when the
        // counter reads 0, so it is occupied for exactly its duration.
        case (state)
          ST_IDLE: begin
            if (start_ok) begin
              mask  <= ch_mask;
              err   <= 1'b0;
              nrst  <= 1'b0;
              busy  <= 1'b1;
              cnt   <= CW'(RST_CYCLES - 1);
              state <= ST_NRST_HOLD;
            end
          end
          ST_NRST_HOLD: begin
            if (cnt_zero) begin
              swim_oe <= mask;
              cnt     <= CW'(START_LOW_CYCLES - 1);
              state   <= ST_ENTRY_LOW;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_ENTRY_LOW: begin
            if (cnt_zero) begin
              swim_oe <= '0;
              cnt     <= CW'(START_HIGH_CYCLES - 1);
              state   <= ST_ENTRY_HIGH;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_ENTRY_HIGH: begin
            if (cnt_zero) begin
              bit_idx <= BW'(PAT_WIDTH - 1);
              swim_oe <= PATTERN[PAT_WIDTH-1] ? '0 : mask;
              cnt     <= CW'(BIT_CYCLES - 1);
              state   <= ST_PATTERN;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_PATTERN: begin
            if (cnt_zero) begin
              if (bit_idx == '0) begin
                swim_oe <= '0;
                cnt     <= CW'(SYNC_TIMEOUT_CYCLES - 1);
                state   <= ST_SYNC_WAIT;
              end else begin
                bit_idx <= next_idx;
                swim_oe <= PATTERN[next_idx] ? '0 : mask;
                cnt     <= CW'(BIT_CYCLES - 1);
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_SYNC_WAIT: begin
            if (all_acked || cnt_zero) begin
              cnt   <= CW'(END_CYCLES - 1);
              state <= ST_END;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_END: begin
            if (cnt_zero) begin
              nrst  <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              err   <= |(mask & ~ack_int);
              state <= ST_IDLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_det
    swim_sync_det #(
      .SYNC_MIN_CYCLES(SYNC_MIN_CYCLES)
    ) u_det (
      .clk    (clk),
      .rst    (rst),
      .swim_in(swim_in[i]),
      .en     (sync_en & mask[i]),
      .clear  (start_ok),
      .ack    (ack_int[i])
    );
  end

  assign ack = ack_int;

endmodule

// File: tb/tb_swim_entry_seq.sv
// Randomised self-checking bench for swim_entry_seq against a cycle-index waveform model.
module tb_swim_entry_seq;

  localparam int T_RST  = 10;
  localparam int T_LOW  = 2;
  localparam int T_HIGH = 10;
  localparam int T_BIT  = 4;
  localparam int PW     = 8;
  localparam int T_SMIN = 3;
  localparam int T_TO   = 40;
  localparam int T_END  = 20;
  localparam int D      = T_RST + T_LOW + T_HIGH + PW * T_BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] ch_mask = '0;
  logic [2:0] swim_in = '1;
  logic [2:0] swim_oe;
  logic       nrst;
  logic       busy;
  logic       done;
  logic [2:0] ack;
  logic       err;

  always #5 clk = ~clk;

  swim_entry_seq #(
    .NUM_CH(3), .RST_CYCLES(T_RST), .START_LOW_CYCLES(T_LOW), .START_HIGH_CYCLES(T_HIGH),
    .BIT_CYCLES(T_BIT), .PAT_WIDTH(PW), .PATTERN(8'hA5), .SYNC_MIN_CYCLES(T_SMIN),
    .SYNC_TIMEOUT_CYCLES(T_TO), .END_CYCLES(T_END)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ch_mask(ch_mask), .swim_in(swim_in),
    .swim_oe(swim_oe), .nrst(nrst), .busy(busy), .done(done), .ack(ack), .err(err)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Target model: channel c holds its line low for pl[c] cycles starting pk[c]
  // cycles after sync-wait entry (negative = already low at entry, 0 length = silent).
  int pk[3];
  int pl[3];
  int abort_at = -1;
  int restart_at = -1;
  logic [2:0] restart_mask = '0;

  int r_oe_bad, r_busy_bad, r_busy_len;
  logic [2:0] r_ack;
  logic r_err, r_done, r_nrst_end, r_done_next, r_timeout;

  function automatic logic [2:0] exp_oe_at(input logic [2:0] m, input int i);
    logic [7:0] pat;
    int b;
    pat = 8'hA5;
    if (i < T_RST) return 3'b000;
    if (i < T_RST + T_LOW) return m;
    if (i < T_RST + T_LOW + T_HIGH) return 3'b000;
    if (i >= D) return 3'b000;
    b = (i - (T_RST + T_LOW + T_HIGH)) / T_BIT;
    return pat[PW-1-b] ? 3'b000 : m;
  endfunction

  function automatic void model_sync(input logic [2:0] m, output logic [2:0] ea,
                                     output int lo, output int hi);
    int last;
    last = 0;
    ea = '0;
    for (int c = 0; c < 3; c++)
      if (m[c] && pl[c] >= T_SMIN && pk[c] >= 0) begin
        ea[c] = 1'b1;
        if (pk[c] + pl[c] > last) last = pk[c] + pl[c];
      end
    if (ea == m) begin lo = last + 1; hi = last + 6; end
    else begin lo = T_TO; hi = T_TO; end
  endfunction

  function automatic void silence();
    for (int c = 0; c < 3; c++) begin pk[c] = 0; pl[c] = 0; end
  endfunction

  task automatic run_seq(input logic [2:0] m);
    bit fin;
    fin = 0;
    r_oe_bad = 0; r_busy_bad = 0; r_busy_len = 0; r_timeout = 0;
    @(posedge clk); #1;
    ch_mask = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ch_mask = 3'($urandom);
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 3; c++)
        swim_in[c] = !(pl[c] > 0 && i >= D + pk[c] && i < D + pk[c] + pl[c]);
      abort = (i == abort_at);
      start = (i == restart_at);
      if (i == restart_at) ch_mask = restart_mask;
      @(negedge clk);
      if (!busy) begin
        r_done = done; r_nrst_end = nrst; r_ack = ack; r_err = err;
        fin = 1;
        break;
      end
      r_busy_len++;
      if (swim_oe !== exp_oe_at(m, i)) r_oe_bad++;
      if (nrst !== 1'b0 || done !== 1'b0) r_busy_bad++;
      @(posedge clk); #1;
    end
    abort = 1'b0; start = 1'b0; swim_in = '1;
    if (!fin) r_timeout = 1'b1;
    @(negedge clk);
    r_done_next = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (swim_oe !== 3'b000) begin n_bad++; $display("FAIL reset_oe got %b want 000", swim_oe); end
    n_vec++; if (nrst !== 1'b1) begin n_bad++; $display("FAIL reset_nrst got %b want 1", nrst); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (ack !== 3'b000) begin n_bad++; $display("FAIL reset_ack got %b want 000", ack); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    rst = 1'b0;
  endtask

  task automatic check_full(input string tag, input logic [2:0] m);
    logic [2:0] ea;
    int lo, hi;
    model_sync(m, ea, lo, hi);
    run_seq(m);
    n_vec++; if (r_timeout) begin n_bad++; $display("FAIL %s_timeout busy never dropped", tag); end
    n_vec++; if (r_oe_bad != 0) begin n_bad++; $display("FAIL %s_oe %0d bad cycles want 0", tag, r_oe_bad); end
    n_vec++; if (r_busy_bad != 0) begin n_bad++; $display("FAIL %s_nrst_busy %0d bad cycles want 0", tag, r_busy_bad); end
    n_vec++; if (r_busy_len < D + lo + T_END || r_busy_len > D + hi + T_END) begin
      n_bad++; $display("FAIL %s_len got %0d want %0d..%0d", tag, r_busy_len, D + lo + T_END, D + hi + T_END);
    end
    n_vec++; if (r_done !== 1'b1 || r_nrst_end !== 1'b1) begin
      n_bad++; $display("FAIL %s_end done=%b nrst=%b want 1 1", tag, r_done, r_nrst_end);
    end
    n_vec++; if (r_ack !== ea) begin n_bad++; $display("FAIL %s_ack got %b want %b", tag, r_ack, ea); end
    n_vec++; if (r_err !== ((m & ~ea) != 0)) begin
      n_bad++; $display("FAIL %s_err got %b want %b", tag, r_err, ((m & ~ea) != 0));
    end
    n_vec++; if (r_done_next !== 1'b0) begin n_bad++; $display("FAIL %s_done_width got %b want 0", tag, r_done_next); end
  endtask

  task automatic test_basic();
    silence();
    pk[0] = 2; pl[0] = 5; pk[2] = 4; pl[2] = 5; pk[1] = 1; pl[1] = 5;
    check_full("basic", 3'b101);
  endtask

  task automatic test_silent_target();
    silence();
    pk[0] = 3; pl[0] = 5;
    check_full("silent", 3'b101);
    n_vec++; if (r_busy_len != D + T_TO + T_END) begin
      n_bad++; $display("FAIL silent_exact_len got %0d want %0d", r_busy_len, D + T_TO + T_END);
    end
  endtask

  task automatic test_min_width();
    silence();
    pk[0] = 1; pl[0] = T_SMIN - 1; pk[1] = 6; pl[1] = T_SMIN;
    check_full("minwidth", 3'b011);
  endtask

  task automatic test_abort();
    silence();
    pk[0] = 2; pl[0] = 5;
    abort_at = D - PW * T_BIT + $urandom_range(0, PW * T_BIT - 1);
    run_seq(3'b111);
    n_vec++; if (r_busy_len != abort_at + 1) begin
      n_bad++; $display("FAIL abort_len got %0d want %0d", r_busy_len, abort_at + 1);
    end
    n_vec++; if (r_oe_bad != 0) begin n_bad++; $display("FAIL abort_oe %0d bad cycles want 0", r_oe_bad); end
    n_vec++; if (r_done !== 1'b1 || r_nrst_end !== 1'b1 || r_err !== 1'b1) begin
      n_bad++; $display("FAIL abort_end done=%b nrst=%b err=%b want 1 1 1", r_done, r_nrst_end, r_err);
    end
    n_vec++; if (r_ack !== 3'b000) begin n_bad++; $display("FAIL abort_ack got %b want 000", r_ack); end
    n_vec++; if (swim_oe !== 3'b000) begin n_bad++; $display("FAIL abort_oe_after got %b want 000", swim_oe); end
    abort_at = -1;
    silence();
    pk[0] = 0; pl[0] = 4; pk[1] = 5; pl[1] = 3; pk[2] = 2; pl[2] = 6;
    check_full("after_abort", 3'b111);
  endtask

  task automatic test_ignored_starts();
    logic [2:0] ea;
    int lo, hi;
    @(posedge clk); #1;
    ch_mask = 3'b000; start = 1'b1;
    @(posedge clk); #1;
    ch_mask = 3'b111; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || nrst !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL idle_ignore busy=%b nrst=%b done=%b want 0 1 0", busy, nrst, done);
    end
    silence();
    pk[1] = 3; pl[1] = 4;
    restart_at = $urandom_range(1, D + 10);
    restart_mask = 3'b101;
    check_full("restart_busy", 3'b010);
    restart_at = -1;
    model_sync(3'b010, ea, lo, hi);
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_vec++; if (ack !== ea || busy !== 1'b0) begin
      n_bad++; $display("FAIL ack_hold ack=%b busy=%b want %b 0", ack, busy, ea);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    ch_mask = 3'b111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (T_RST) @(posedge clk);
    #1;
    @(negedge clk);
    n_vec++; if (swim_oe !== 3'b111) begin n_bad++; $display("FAIL entry_low_oe got %b want 111", swim_oe); end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (swim_oe !== 3'b000 || nrst !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ack !== 3'b000 || err !== 1'b0) begin
      n_bad++; $display("FAIL midrst_outputs oe=%b nrst=%b busy=%b done=%b ack=%b err=%b want 000 1 0 0 000 0",
                        swim_oe, nrst, busy, done, ack, err);
    end
    rst = 1'b0;
    silence();
    pk[0] = -4; pl[0] = 9; pk[1] = 2; pl[1] = 3; pk[2] = 7; pl[2] = 4;
    check_full("inprogress", 3'b111);
  endtask

  task automatic test_random();
    logic [2:0] m;
    for (int it = 0; it < 10; it++) begin
      m = 3'($urandom_range(1, 7));
      for (int c = 0; c < 3; c++) begin
        int kind;
        kind = (it % 2 == 0 && m[c]) ? 2 : $urandom_range(0, 3);
        case (kind)
          0: begin pk[c] = 0; pl[c] = 0; end
          1: begin pk[c] = $urandom_range(0, 10); pl[c] = $urandom_range(1, T_SMIN - 1); end
          2: begin pk[c] = $urandom_range(0, 10); pl[c] = $urandom_range(T_SMIN, 6); end
          default: begin pk[c] = -$urandom_range(3, 6); pl[c] = -pk[c] + $urandom_range(1, 5); end
        endcase
      end
      check_full("random", m);
    end
  endtask

  initial begin
    silence();
    test_reset();
    test_basic();
    test_silent_target();
    test_min_width();
    test_abort();
    test_ignored_starts();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
